sprite_pos_ctrl: RTL and testbench
==================================

Name: sprite_pos_ctrl

Overview:
- Moves a square sprite one step per N frames in the direction reported by the button-memory block.
- Sits between button direction memory (upstream, 2-bit `pressed`) and the pixel colour stage (downstream, consumes `box_x`/`box_y`).
- Position updates only in vertical blanking, keyed off a one-cycle frame tick from the timing generator, so no frame tears.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BOX_W, 32, sprite width in pixels
- BOX_H, 32, sprite height in lines
- FRAME_DIV, 1, frame ticks per position step (1..255)

Ports:
- clk  in  1  system clock (100 MHz domain)
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-clk pulse at start of vertical blanking
- pressed  in  2  direction: 00 up, 01 down, 10 left, 11 right
- move_en  in  1  level; movement allowed when high
- recenter  in  1  synchronous one-clk request to return sprite to centre
- speed  in  4  pixels per step, 0..15
- box_x  out  10  sprite left edge, 0..H_ACTIVE-BOX_W
- box_y  out  9  sprite top edge, 0..V_ACTIVE-BOX_H
- edge_hit  out  1  one-clk pulse when a step was clamped at a boundary

Behaviour:
- Reset (async, immediate):
  - box_x = (H_ACTIVE-BOX_W)/2 = 304; box_y = (V_ACTIVE-BOX_H)/2 = 224
  - edge_hit = 0; frame counter = 0; state = S_IDLE
- States:
  - S_IDLE: position held; counter held at 0. Go to S_WAIT when move_en=1.
  - S_WAIT: each frame_tick increments counter. When a tick arrives with counter = FRAME_DIV-1: clear counter, latch `pressed` and `speed`, go to S_UPDATE. move_en=0 returns to S_IDLE and clears counter.
  - S_UPDATE: exactly one cycle. Registers new box_x/box_y and edge_hit, then returns to S_WAIT (or S_IDLE if move_en=0).
    - A frame_tick arriving during S_UPDATE is counted, not lost.
- Latency: the decisive frame_tick is at cycle T; the new position and edge_hit are visible at T+2 (latch at T+1, register at T+2).
- Arithmetic (11-bit unsigned intermediates; no wrap-around ever):
  - right: x+speed > H_ACTIVE-BOX_W → clamp to H_ACTIVE-BOX_W, pulse edge_hit
  - left: speed > x → clamp to 0, pulse edge_hit
  - down: y+speed > V_ACTIVE-BOX_H → clamp to V_ACTIVE-BOX_H, pulse edge_hit
  - up: speed > y → clamp to 0, pulse edge_hit
  - Only the axis selected by the latched direction changes.
- edge_hit details:
  - Pulses even when the sprite is already at the edge and a nonzero step pushes outward.
  - speed = 0: no movement and no edge_hit.
  - edge_hit is high for exactly one cycle, coincident with the position update.
- recenter:
  - Highest priority in any state. Next cycle: box_x/box_y = centre, counter cleared, edge_hit = 0.
  - State goes to S_WAIT if move_en=1, else S_IDLE.
  - Overrides an S_UPDATE in the same cycle; the step is discarded.
- Inputs are synchronous to clk. `pressed` changes between tick and latch are ignored until the next step.
- Reset asserted mid-S_UPDATE: outputs go to reset values immediately; no partial update survives.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE constants
  - direction encodings DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT, shared with the button memory block
  - the 2-bit state typedef
- One sub-module, axis_clamp: combinational step + clamp for one axis (pos, speed, dir_neg, max → new_pos, clamped). Instantiated twice (x with max H_ACTIVE-BOX_W, y with max V_ACTIVE-BOX_H).

Test Plan:
- Reset release, move_en=0, 5 frame ticks → box_x=304, box_y=224, edge_hit never high.
- move_en=1, pressed=11, speed=4, FRAME_DIV=1, tick at T → box_x=308 at T+2, box_y=224, edge_hit=0.
- Sprite at box_x=604, pressed=11, speed=8, tick → box_x=608, edge_hit high exactly one cycle. Second tick → box_x=608, edge_hit pulses again.
- Sprite at box_y=4, pressed=00, speed=8, tick → box_y=0, edge_hit pulse. Repeat with speed=0 → box_y=0, no pulse.
- FRAME_DIV=4, pressed=10, speed=2:
  - Ticks 1–3 → box_x unchanged; tick 4 → box_x=302.
  - Drop move_en after tick 2, then re-raise → four further ticks needed.
- recenter pulsed in the same cycle as S_UPDATE → box_x=304, box_y=224 next cycle, no edge_hit. Then async rst asserted mid-S_UPDATE → outputs at reset values within the same cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants, button direction encodings and the sprite controller state type.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Same encoding as the button direction memory block
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_UPDATE = 2'b10
  } state_e;

endpackage

// File: rtl/axis_clamp.sv
// Combinational one-axis step: moves pos by speed toward 0 or max and clamps at either end.
module axis_clamp #(
  parameter int W   = 10,
  parameter int MAX = 608
) (
  input  logic [W-1:0] pos,
  input  logic [3:0]   speed,
  input  logic         dir_neg,
  output logic [W-1:0] new_pos,
  output logic         clamped
);

  logic [10:0] pos_w;
  logic [10:0] spd_w;
  logic [10:0] sum_w;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    new_pos = pos;
    clamped = 1'b0;
    pos_w   = 11'(pos);
    spd_w   = 11'(speed);
    sum_w   = pos_w + spd_w;
    if (dir_neg) begin
      if (spd_w > pos_w) begin
        new_pos = '0;
        clamped = 1'b1;
      end else begin
        new_pos = W'(pos_w - spd_w);
      end
    end else begin
      if (sum_w > 11'(MAX)) begin
        new_pos = W'(MAX);
        clamped = 1'b1;
      end else begin
        new_pos = W'(sum_w);
      end
    end
  end

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Steps a square sprite once every FRAME_DIV frame ticks in the latched button direction,
// clamping at the screen edges; all position changes happen in vertical blanking.
module sprite_pos_ctrl #(
  parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int BOX_W     = 32,
  parameter int BOX_H     = 32,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] pressed,
  input  logic       move_en,
  input  logic       recenter,
  input  logic [3:0] speed,
  output logic [9:0] box_x,
  output logic [8:0] box_y,
  output logic       edge_hit
);

  import vga_pkg::*;

  localparam int          X_MAX    = H_ACTIVE - BOX_W;
  localparam int          Y_MAX    = V_ACTIVE - BOX_H;
  localparam logic [9:0]  X_CENTRE = 10'(X_MAX / 2);
  localparam logic [8:0]  Y_CENTRE = 9'(Y_MAX / 2);
  localparam logic [8:0]  DIV      = 9'(FRAME_DIV);
  localparam logic [8:0]  DIV_M1   = 9'(FRAME_DIV - 1);

  state_e     state;
  logic [8:0] cnt;
  dir_e       dir_q;
  logic [3:0] speed_q;

  logic [9:0] x_next;
  logic [8:0] y_next;
  logic       x_clamped;
  logic       y_clamped;
  logic       x_axis;
  logic       fire;

  axis_clamp #(.W(10), .MAX(X_MAX)) u_x_clamp (
    .pos     (box_x),
    .speed   (speed_q),
    .dir_neg (dir_q == DIR_LEFT),
    .new_pos (x_next),
    .clamped (x_clamped)
  );

  axis_clamp #(.W(9), .MAX(Y_MAX)) u_y_clamp (
    .pos     (box_y),
    .speed   (speed_q),
    .dir_neg (dir_q == DIR_UP),
    .new_pos (y_next),
    .clamped (y_clamped)
  );

  assign x_axis = (dir_q == DIR_LEFT) || (dir_q == DIR_RIGHT);

  // A tick seen during S_UPDATE can leave cnt at DIV; that owed step fires without a new tick.
  assign fire = (cnt >= DIV) || (frame_tick && (cnt == DIV_M1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: nonblocking assignments for all state so every register samples pre-edge values.
      state    <= S_IDLE;
      cnt      <= '0;
      dir_q    <= DIR_UP;
      speed_q  <= '0;
      box_x    <= X_CENTRE;
      box_y    <= Y_CENTRE;
      edge_hit <= 1'b0;
    end else if (recenter) begin
      box_x    <= X_CENTRE;
      box_y    <= Y_CENTRE;
      cnt      <= '0;
      edge_hit <= 1'b0;
      state    <= move_en ? S_WAIT : S_IDLE;
    end else begin
      edge_hit <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (move_en) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!move_en) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (fire) begin
            cnt     <= '0;
            dir_q   <= dir_e'(pressed);
            speed_q <= speed;
            state   <= S_UPDATE;
          end else if (frame_tick) begin
            cnt <= cnt + 9'd1;
          end
        end
        S_UPDATE: begin
          if (x_axis) begin
            box_x    <= x_next;
            edge_hit <= x_clamped;
          end else begin
            box_y    <= y_next;
            edge_hit <= y_clamped;
          end
          if (!move_en) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            state <= S_WAIT;
            if (frame_tick) cnt <= cnt + 9'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Directed bench for sprite_pos_ctrl: one instance with FRAME_DIV=1, one with FRAME_DIV=4.
module tb_sprite_pos_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] pressed = 2'b00;
  logic       move_en = 1'b0;
  logic       recenter = 1'b0;
  logic [3:0] speed = 4'd0;

  logic [9:0] box_x, box4_x;
  logic [8:0] box_y, box4_y;
  logic       edge_hit, edge4_hit;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sprite_pos_ctrl #(.FRAME_DIV(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .pressed    (pressed),
    .move_en    (move_en),
    .recenter   (recenter),
    .speed      (speed),
    .box_x      (box_x),
    .box_y      (box_y),
    .edge_hit   (edge_hit)
  );

  sprite_pos_ctrl #(.FRAME_DIV(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .pressed    (pressed),
    .move_en    (move_en),
    .recenter   (recenter),
    .speed      (speed),
    .box_x      (box4_x),
    .box_y      (box4_y),
    .edge_hit   (edge4_hit)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Tick for one cycle; returns at the negedge right after the position register edge.
  task automatic tick_step();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_recenter();
    @(negedge clk) recenter = 1'b1;
    @(negedge clk) recenter = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_x", box_x, 304);
    check("rst_y", box_y, 224);
    check("rst_edge", edge_hit, 0);
    check("rst_x4", box4_x, 304);
    @(negedge clk) rst = 1'b0;

    // move_en low: ticks must not move anything
    for (int i = 0; i < 5; i++) begin
      tick_step();
      check("idle_edge", edge_hit, 0);
    end
    check("idle_x", box_x, 304);
    check("idle_y", box_y, 224);

    // Right by 4, with latency check
    move_en = 1'b1; pressed = 2'b11; speed = 4'd4;
    @(negedge clk);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check("lat_t1_x", box_x, 304);
    @(negedge clk);
    check("lat_t2_x", box_x, 308);
    check("lat_t2_y", box_y, 224);
    check("lat_t2_edge", edge_hit, 0);

    // Walk to x=604, then push into the right edge twice
    do_recenter();
    speed = 4'd15;
    for (int i = 0; i < 20; i++) tick_step();
    check("walk_x", box_x, 604);
    check("walk_edge", edge_hit, 0);
    speed = 4'd8;
    tick_step();
    check("rclamp_x", box_x, 608);
    check("rclamp_edge", edge_hit, 1);
    @(negedge clk);
    check("rclamp_edge_1cyc", edge_hit, 0);
    tick_step();
    check("rclamp2_x", box_x, 608);
    check("rclamp2_edge", edge_hit, 1);
    @(negedge clk);
    check("rclamp2_edge_1cyc", edge_hit, 0);

    // Walk up to y=4, clamp at top, then zero speed
    do_recenter();
    pressed = 2'b00; speed = 4'd15;
    for (int i = 0; i < 14; i++) tick_step();
    speed = 4'd10;
    tick_step();
    check("up_y", box_y, 4);
    check("up_x", box_x, 304);
    speed = 4'd8;
    tick_step();
    check("uclamp_y", box_y, 0);
    check("uclamp_edge", edge_hit, 1);
    @(negedge clk);
    check("uclamp_edge_1cyc", edge_hit, 0);
    speed = 4'd0;
    tick_step();
    check("zero_y", box_y, 0);
    check("zero_edge", edge_hit, 0);

    // FRAME_DIV=4: left by 2 on every fourth tick
    do_recenter();
    pressed = 2'b10; speed = 4'd2;
    for (int i = 1; i <= 3; i++) begin
      tick_step();
      check("div4_hold_x", box4_x, 304);
    end
    tick_step();
    check("div4_step_x", box4_x, 302);
    check("div4_step_edge", edge4_hit, 0);

    // Dropping move_en after two ticks restarts the count
    do_recenter();
    tick_step();
    tick_step();
    @(negedge clk) move_en = 1'b0;
    repeat (3) @(negedge clk);
    move_en = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      tick_step();
      check("div4_restart_hold_x", box4_x, 304);
    end
    tick_step();
    check("div4_restart_step_x", box4_x, 302);

    // recenter in the S_UPDATE cycle discards the step
    do_recenter();
    pressed = 2'b11; speed = 4'd4;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) begin
      frame_tick = 1'b0;
      recenter   = 1'b1;
    end
    @(negedge clk) recenter = 1'b0;
    check("rc_upd_x", box_x, 304);
    check("rc_upd_y", box_y, 224);
    check("rc_upd_edge", edge_hit, 0);
    @(negedge clk);
    check("rc_upd_x_later", box_x, 304);

    // Async reset during S_UPDATE
    tick_step();
    check("pre_rst_x", box_x, 308);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_x", box_x, 304);
    check("rst_mid_y", box_y, 224);
    check("rst_mid_edge", edge_hit, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rst_mid_x_after", box_x, 304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
